// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of one shared memory port.
// Define MEM_ARB_RR_EN to get round-robin arbitration instead of fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;
    logic   owner_d_q;  // 1: data port owns the in-flight transaction
    logic   pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;     // 1: data port won the previous grant

    assign pick_d = d_req && (!if_req || !last_d_q);
`else
    assign pick_d = d_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_req || d_req) state_d = BUSY;
            BUSY:    if (m_ready)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        m_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    d_gnt  = pick_d;
                    if_gnt = if_req && !pick_d;
                end
            end
            BUSY:    m_req = 1'b1;
            default: m_req = 1'b0;
        endcase
    end

    // NOTE: the request registers are reset as well so the memory bus shows
    // defined zeros after reset instead of stale fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_we      <= 1'b0;
            m_be      <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            owner_d_q <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (d_gnt) begin
                m_we      <= d_we;
                m_be      <= d_be;
                m_addr    <= d_addr;
                m_wdata   <= d_wdata;
                owner_d_q <= 1'b1;
            end else if (if_gnt) begin
                m_we      <= 1'b0;
                m_be      <= '1;
                m_addr    <= if_addr;
                m_wdata   <= '0;
                owner_d_q <= 1'b0;
            end

`ifdef MEM_ARB_RR_EN
            if (d_gnt || if_gnt) last_d_q <= d_gnt;
`endif

            // Writes still get an rvalid pulse as a completion ack, but leave rdata alone.
            if (state_q == BUSY && m_ready) begin
                if (owner_d_q) begin
                    d_rvalid <= 1'b1;
                    if (!m_we) d_rdata <= m_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if (!m_we) if_rdata <= m_rdata;
                end
            end
        end
    end

endmodule
